prf_bypass_table: RTL and testbench

Next-generation physical register file for the out-of-order core. Write, read, free and flush port counts are parametrised. Reads are registered with a fixed 1-cycle latency and write-first bypass. Each read returns a per-operand ready bit, and the block raises a sticky error flag on same-cycle write collisions. Sits between the rename/free-list logic, the issue stage (read ports) and the functional-unit writeback buses.

---
 rtl/prf_bypass_table.sv | 145 ++++++++++++++
 tb/tb_prf_bypass_table.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_bypass_table.sv
// Physical register file with registered, write-first bypassed read channels,
// per-tag valid tracking with commit/flush invalidation, and a sticky write-collision flag.
module prf_bypass_table #(
    parameter int DATA_WIDTH  = 32,
    parameter int PRF_ENTRY   = 64,
    parameter int WR_PORTS    = 8,
    parameter int RD_PORTS    = 6,
    parameter int FREE_PORTS  = 2,
    parameter int FLUSH_PORTS = 32,
    parameter int TAG_W       = $clog2(PRF_ENTRY)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [WR_PORTS-1:0]                   wr_en,
    input  logic [WR_PORTS-1:0][TAG_W-1:0]        wr_tag,
    input  logic [WR_PORTS-1:0][DATA_WIDTH-1:0]   wr_data,
    input  logic [RD_PORTS-1:0]                   rd_en,
    input  logic [RD_PORTS-1:0][TAG_W-1:0]        rd_tag1,
    input  logic [RD_PORTS-1:0][TAG_W-1:0]        rd_tag2,
    output logic [RD_PORTS-1:0]                   rd_vld,
    output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]   rd_data1,
    output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]   rd_data2,
    output logic [RD_PORTS-1:0]                   rd_rdy1,
    output logic [RD_PORTS-1:0]                   rd_rdy2,
    input  logic [FREE_PORTS-1:0]                 free_en,
    input  logic [FREE_PORTS-1:0][TAG_W-1:0]      free_tag,
    input  logic [FLUSH_PORTS-1:0]                flush_v,
    input  logic [FLUSH_PORTS-1:0][TAG_W-1:0]     flush_tag,
    output logic [PRF_ENTRY-1:0]                  valid_array,
    output logic                                  wr_conflict
);

    // Read handshake: rd_en[c] is a one-cycle request with no back-pressure; the
    // result appears with rd_vld[c]=1 for exactly one cycle after the sampling edge.
    logic [DATA_WIDTH-1:0]                 mem_q [PRF_ENTRY];
    logic [DATA_WIDTH-1:0]                 mem_d [PRF_ENTRY];
    logic [PRF_ENTRY-1:0]                  valid_q, valid_d;
    logic                                  conflict_q, conflict_d;
    logic [RD_PORTS-1:0]                   rd_vld_q, rd_vld_d;
    logic [RD_PORTS-1:0][DATA_WIDTH-1:0]   rd_data1_q, rd_data1_d;
    logic [RD_PORTS-1:0][DATA_WIDTH-1:0]   rd_data2_q, rd_data2_d;
    logic [RD_PORTS-1:0]                   rd_rdy1_q, rd_rdy1_d;
    logic [RD_PORTS-1:0]                   rd_rdy2_q, rd_rdy2_d;

    logic [PRF_ENTRY-1:0]                  set_mask;
    logic [PRF_ENTRY-1:0]                  free_mask;
    logic [PRF_ENTRY-1:0]                  flush_mask;
    logic                                  conflict_hit;

    // Later ports overwrite earlier ones, so the highest index wins a collision.
    always_comb begin
        for (int e = 0; e < PRF_ENTRY; e++) begin
            mem_d[e] = mem_q[e];
        end
        set_mask     = '0;
        conflict_hit = 1'b0;
        for (int i = 0; i < WR_PORTS; i++) begin
            if (wr_en[i] && (wr_tag[i] != '0)) begin
                if (set_mask[wr_tag[i]]) begin
                    conflict_hit = 1'b1;
                end
                set_mask[wr_tag[i]] = 1'b1;
                mem_d[wr_tag[i]]    = wr_data[i];
            end
        end
    end

    always_comb begin
        free_mask  = '0;
        flush_mask = '0;
        for (int f = 0; f < FREE_PORTS; f++) begin
            if (free_en[f] && (free_tag[f] != '0)) begin
                free_mask[free_tag[f]] = 1'b1;
            end
        end
        for (int f = 0; f < FLUSH_PORTS; f++) begin
            if (flush_v[f] && (flush_tag[f] != '0)) begin
                flush_mask[flush_tag[f]] = 1'b1;
            end
        end
    end

    // Invalidation is applied after the write set so a same-cycle clear wins.
    always_comb begin
        valid_d    = (valid_q | set_mask) & ~(free_mask | flush_mask);
        valid_d[0] = 1'b1;
        conflict_d = conflict_q | conflict_hit;
    end

    // Read data and ready come from next-state storage, giving write-first bypass.
    always_comb begin
        rd_vld_d   = rd_en;
        rd_data1_d = '0;
        rd_data2_d = '0;
        rd_rdy1_d  = '0;
        rd_rdy2_d  = '0;
        for (int c = 0; c < RD_PORTS; c++) begin
            if (rd_en[c]) begin
                rd_rdy1_d[c] = valid_d[rd_tag1[c]];
                rd_rdy2_d[c] = valid_d[rd_tag2[c]];
                if (rd_tag1[c] != '0) begin
                    rd_data1_d[c] = mem_d[rd_tag1[c]];
                end
                if (rd_tag2[c] != '0) begin
                    rd_data2_d[c] = mem_d[rd_tag2[c]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < PRF_ENTRY; e++) begin
            mem_q[e] <= mem_d[e];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= PRF_ENTRY'(1);
            conflict_q <= 1'b0;
            rd_vld_q   <= '0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_rdy1_q  <= '0;
            rd_rdy2_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            rd_vld_q   <= rd_vld_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_rdy1_q  <= rd_rdy1_d;
            rd_rdy2_q  <= rd_rdy2_d;
        end
    end

    assign valid_array = {valid_q[PRF_ENTRY-1:1], 1'b1};
    assign wr_conflict = conflict_q;
    assign rd_vld      = rd_vld_q;
    assign rd_data1    = rd_data1_q;
    assign rd_data2    = rd_data2_q;
    assign rd_rdy1     = rd_rdy1_q;
    assign rd_rdy2     = rd_rdy2_q;

endmodule

// File: tb/tb_prf_bypass_table.sv
// Bench for prf_bypass_table: directed scenarios plus random traffic checked
// against a tag-level reference model through per-channel expected queues.
module tb_prf_bypass_table;

    localparam int DW  = 32;
    localparam int NE  = 64;
    localparam int WRP = 8;
    localparam int RDP = 6;
    localparam int FRP = 2;
    localparam int FLP = 32;
    localparam int TW  = $clog2(NE);
    localparam int EW  = 2 * DW + 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [WRP-1:0]             wr_en;
    logic [WRP-1:0][TW-1:0]     wr_tag;
    logic [WRP-1:0][DW-1:0]     wr_data;
    logic [RDP-1:0]             rd_en;
    logic [RDP-1:0][TW-1:0]     rd_tag1;
    logic [RDP-1:0][TW-1:0]     rd_tag2;
    logic [RDP-1:0]             rd_vld;
    logic [RDP-1:0][DW-1:0]     rd_data1;
    logic [RDP-1:0][DW-1:0]     rd_data2;
    logic [RDP-1:0]             rd_rdy1;
    logic [RDP-1:0]             rd_rdy2;
    logic [FRP-1:0]             free_en;
    logic [FRP-1:0][TW-1:0]     free_tag;
    logic [FLP-1:0]             flush_v;
    logic [FLP-1:0][TW-1:0]     flush_tag;
    logic [NE-1:0]              valid_array;
    logic                       wr_conflict;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_data [NE];
    bit            m_valid [NE];
    bit            m_conflict;
    logic [EW-1:0] exp_q [RDP][$];

    prf_bypass_table #(
        .DATA_WIDTH(DW), .PRF_ENTRY(NE), .WR_PORTS(WRP), .RD_PORTS(RDP),
        .FREE_PORTS(FRP), .FLUSH_PORTS(FLP), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_tag(wr_tag), .wr_data(wr_data),
        .rd_en(rd_en), .rd_tag1(rd_tag1), .rd_tag2(rd_tag2),
        .rd_vld(rd_vld), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_rdy1(rd_rdy1), .rd_rdy2(rd_rdy2),
        .free_en(free_en), .free_tag(free_tag),
        .flush_v(flush_v), .flush_tag(flush_tag),
        .valid_array(valid_array), .wr_conflict(wr_conflict)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [TW-1:0] tag);
        return (tag == '0) ? '0 : m_data[tag];
    endfunction

    function automatic logic [NE-1:0] model_vec();
        logic [NE-1:0] v;
        for (int t = 0; t < NE; t++) v[t] = m_valid[t];
        return v;
    endfunction

    // driver tasks
    task automatic clear_inputs();
        wr_en = '0; wr_tag = '0; wr_data = '0;
        rd_en = '0; rd_tag1 = '0; rd_tag2 = '0;
        free_en = '0; free_tag = '0;
        flush_v = '0; flush_tag = '0;
    endtask

    // Applies the current inputs to the model, queues read expectations, and
    // advances one cycle, then checks the architectural state.
    task automatic step();
        bit wrote [NE];
        bit clr [NE];
        for (int t = 0; t < NE; t++) begin
            wrote[t] = 0;
            clr[t]   = 0;
        end
        if (rst) begin
            for (int t = 0; t < NE; t++) m_valid[t] = 0;
            m_valid[0] = 1;
            m_conflict = 0;
        end else begin
            for (int i = 0; i < WRP; i++) begin
                if (wr_en[i] && wr_tag[i] != 0) begin
                    if (wrote[wr_tag[i]]) m_conflict = 1;
                    wrote[wr_tag[i]]  = 1;
                    m_data[wr_tag[i]] = wr_data[i];
                end
            end
            for (int f = 0; f < FRP; f++)
                if (free_en[f] && free_tag[f] != 0) clr[free_tag[f]] = 1;
            for (int f = 0; f < FLP; f++)
                if (flush_v[f] && flush_tag[f] != 0) clr[flush_tag[f]] = 1;
            for (int t = 1; t < NE; t++)
                m_valid[t] = (m_valid[t] || wrote[t]) && !clr[t];
            for (int c = 0; c < RDP; c++) begin
                if (rd_en[c]) begin
                    exp_q[c].push_back({model_read(rd_tag1[c]), 1'(m_valid[rd_tag1[c]]),
                                        model_read(rd_tag2[c]), 1'(m_valid[rd_tag2[c]])});
                end
            end
        end
        @(negedge clk);
        chk("valid_array", valid_array, model_vec());
        chk("wr_conflict", wr_conflict, m_conflict);
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        #2;
        for (int c = 0; c < RDP; c++) begin
            if (rd_vld[c]) begin
                if (exp_q[c].size() == 0) begin
                    chk("rd_unexpected", rd_vld[c], 1'b0);
                end else begin
                    chk("rd_result", {rd_data1[c], rd_rdy1[c], rd_data2[c], rd_rdy2[c]},
                        exp_q[c].pop_front());
                end
            end else begin
                chk("rd_idle", {rd_data1[c], rd_rdy1[c], rd_data2[c], rd_rdy2[c]}, '0);
                if (exp_q[c].size() != 0) begin
                    chk("rd_missing", rd_vld[c], 1'b1);
                    void'(exp_q[c].pop_front());
                end
            end
        end
    end

    task automatic read1(input int c, input int tag);
        rd_en[c] = 1'b1; rd_tag1[c] = TW'(tag); rd_tag2[c] = TW'(tag);
    endtask

    initial begin
        m_conflict = 0;
        for (int t = 0; t < NE; t++) begin
            m_valid[t] = (t == 0);
            m_data[t]  = '0;
        end
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        step();
        rst = 1'b0;

        // give every tag known contents, then invalidate everything via flush
        for (int b = 1; b < NE; b += WRP) begin
            clear_inputs();
            for (int i = 0; i < WRP; i++) begin
                if (b + i < NE) begin
                    wr_en[i] = 1'b1; wr_tag[i] = TW'(b + i); wr_data[i] = $urandom;
                end
            end
            step();
        end
        for (int b = 1; b < NE; b += FLP) begin
            clear_inputs();
            for (int f = 0; f < FLP; f++) begin
                if (b + f < NE) begin
                    flush_v[f] = 1'b1; flush_tag[f] = TW'(b + f);
                end
            end
            step();
        end

        // reset with a pending read
        clear_inputs(); rst = 1'b1; read1(0, 5); step();
        rst = 1'b0;
        chk("reset_valid_array", valid_array, 64'h1);
        clear_inputs(); read1(0, 5); step();

        // same-cycle write and read of tag 5
        clear_inputs();
        wr_en[2] = 1'b1; wr_tag[2] = TW'(5); wr_data[2] = 32'hDEADBEEF;
        read1(1, 5); step();
        chk("bypass_valid5", valid_array[5], 1'b1);

        // colliding writes to tag 9
        clear_inputs();
        wr_en[0] = 1'b1; wr_tag[0] = TW'(9); wr_data[0] = 32'h11;
        wr_en[7] = 1'b1; wr_tag[7] = TW'(9); wr_data[7] = 32'h77;
        step();
        chk("conflict_set", wr_conflict, 1'b1);
        clear_inputs(); read1(2, 9); step();
        clear_inputs(); step(); step();
        chk("conflict_sticky", wr_conflict, 1'b1);

        // write and free tag 12 together
        clear_inputs();
        wr_en[1] = 1'b1; wr_tag[1] = TW'(12); wr_data[1] = 32'hC0FFEE12;
        free_en[1] = 1'b1; free_tag[1] = TW'(12);
        step();
        chk("clear_beats_set", valid_array[12], 1'b0);
        clear_inputs(); read1(3, 12); step();

        // flush across the outer ports
        clear_inputs();
        wr_en[0] = 1'b1; wr_tag[0] = TW'(3);  wr_data[0] = $urandom;
        wr_en[1] = 1'b1; wr_tag[1] = TW'(4);  wr_data[1] = $urandom;
        wr_en[2] = 1'b1; wr_tag[2] = TW'(40); wr_data[2] = $urandom;
        step();
        clear_inputs();
        flush_v[0]  = 1'b1; flush_tag[0]  = TW'(3);
        flush_v[15] = 1'b1; flush_tag[15] = TW'(4);
        flush_v[31] = 1'b1; flush_tag[31] = TW'(40);
        step();
        chk("flush_bits", {valid_array[3], valid_array[4], valid_array[40]}, 3'b000);

        // tag 0 is immutable; reset drops an in-flight read
        clear_inputs();
        wr_en[3] = 1'b1; wr_tag[3] = '0; wr_data[3] = 32'hFFFFFFFF;
        read1(3, 0); step();
        clear_inputs(); rst = 1'b1; read1(4, 9); step();
        rst = 1'b0;
        chk("conflict_cleared", wr_conflict, 1'b0);
        clear_inputs(); step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            rst = ($urandom_range(0, 199) == 0);
            if (!rst) begin
                for (int i = 0; i < WRP; i++) begin
                    wr_en[i]   = ($urandom_range(0, 2) == 0);
                    wr_tag[i]  = TW'($urandom_range(0, (n % 4 == 0) ? 15 : NE - 1));
                    wr_data[i] = $urandom;
                end
                for (int f = 0; f < FRP; f++) begin
                    free_en[f]  = ($urandom_range(0, 3) == 0);
                    free_tag[f] = TW'($urandom_range(0, NE - 1));
                end
                for (int f = 0; f < FLP; f++) begin
                    flush_v[f]   = ($urandom_range(0, 19) == 0);
                    flush_tag[f] = TW'($urandom_range(0, NE - 1));
                end
            end
            for (int c = 0; c < RDP; c++) begin
                rd_en[c]   = $urandom_range(0, 1);
                rd_tag1[c] = TW'($urandom_range(0, NE - 1));
                rd_tag2[c] = TW'($urandom_range(0, NE - 1));
            end
            step();
        end
        rst = 1'b0;
        clear_inputs();
        step(); step();

        // final report
        for (int c = 0; c < RDP; c++) chk("leftover_expect", exp_q[c].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
